// File: rtl/spi_arbiter_if.sv
// Signal bundle between the requester clients, spi_arbiter and spi_master.
// The slave modport is the arbiter's view; the master modport is the clients' and master's view.
interface spi_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 14,
    parameter int RW    = 8
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_cs_sel;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic                err;
    logic [RW-1:0]       rd_data;
    logic                spi_tx_valid;
    logic [DW-1:0]       spi_data_in;
    logic                spi_cs_sel;
    logic                spi_rx_ready;
    logic [RW-1:0]       spi_data_out;

    modport slave (
        input  req, req_data, req_cs_sel, spi_rx_ready, spi_data_out,
        output gnt, done, err, rd_data, spi_tx_valid, spi_data_in, spi_cs_sel
    );

    modport master (
        output req, req_data, req_cs_sel, spi_rx_ready, spi_data_out,
        input  gnt, done, err, rd_data, spi_tx_valid, spi_data_in, spi_cs_sel
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among N_REQ requesters, with a
// transfer timeout that aborts when the master never completes a handshake.
module spi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 14,
    parameter int RW      = 8,
    parameter int TIMEOUT = 63
) (
    input  logic         clk,
    input  logic         rst,
    spi_arbiter_if.slave bus
);
    localparam int            IW       = $clog2(N_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
    localparam logic [7:0]    TMO      = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [IW-1:0]     ptr_r, ptr_s;
    logic [IW-1:0]     idx_r, idx_s;
    logic [IW-1:0]     pick_s, idx_inc_s;
    logic [7:0]        timer_r, timer_s;
    logic [N_REQ-1:0]  gnt_r, gnt_s;
    logic [N_REQ-1:0]  done_r, done_s;
    logic              err_r, err_s;
    logic [RW-1:0]     rd_data_r, rd_data_s;
    logic              tx_valid_r, tx_valid_s;
    logic [DW-1:0]     data_in_r, data_in_s;
    logic              cs_sel_r, cs_sel_s;

    // Lowest offset from p wins: scan downwards so the nearest set bit is written last.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] sel;
        int            k;
        sel = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = (int'(p) + i) % N_REQ;
            if (r[k]) begin
                sel = IW'(k);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    assign pick_s    = rr_pick(bus.req, ptr_r);
    assign idx_inc_s = (idx_r == LAST_IDX) ? {IW{1'b0}} : idx_r + 1'b1;

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        idx_s      = idx_r;
        timer_s    = timer_r;
        gnt_s      = gnt_r;
        done_s     = {N_REQ{1'b0}};
        err_s      = 1'b0;
        rd_data_s  = rd_data_r;
        tx_valid_s = 1'b0;
        data_in_s  = data_in_r;
        cs_sel_s   = cs_sel_r;
        case (state_r)
            ST_IDLE: begin
                if (|bus.req) begin
                    idx_s      = pick_s;
                    gnt_s      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
                    data_in_s  = bus.req_data[int'(pick_s) * DW +: DW];
                    cs_sel_s   = bus.req_cs_sel[pick_s];
                    tx_valid_s = 1'b1;
                    state_s    = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_s = 8'd0;
                state_s = ST_WAIT_LO;
            end
            ST_WAIT_LO, ST_WAIT_HI: begin
                if (timer_r == TMO) begin
                    err_s   = 1'b1;
                    gnt_s   = {N_REQ{1'b0}};
                    ptr_s   = idx_inc_s;
                    state_s = ST_IDLE;
                end else begin
                    timer_s = timer_r + 8'd1;
                    // WAIT_LO first sees rx_ready drop, which also swallows a stale high level.
                    if (state_r == ST_WAIT_LO && !bus.spi_rx_ready) begin
                        state_s = ST_WAIT_HI;
                    end else if (state_r == ST_WAIT_HI && bus.spi_rx_ready) begin
                        rd_data_s = bus.spi_data_out;
                        done_s    = gnt_r;
                        state_s   = ST_DONE;
                    end else begin
                        state_s = state_r;
                    end
                end
            end
            ST_DONE: begin
                gnt_s   = {N_REQ{1'b0}};
                ptr_s   = idx_inc_s;
                state_s = ST_IDLE;
            end
            default: begin
                gnt_s   = {N_REQ{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {IW{1'b0}};
            idx_r      <= {IW{1'b0}};
            timer_r    <= 8'd0;
            gnt_r      <= {N_REQ{1'b0}};
            done_r     <= {N_REQ{1'b0}};
            err_r      <= 1'b0;
            rd_data_r  <= {RW{1'b0}};
            tx_valid_r <= 1'b0;
            data_in_r  <= {DW{1'b0}};
            cs_sel_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            idx_r      <= idx_s;
            timer_r    <= timer_s;
            gnt_r      <= gnt_s;
            done_r     <= done_s;
            err_r      <= err_s;
            rd_data_r  <= rd_data_s;
            tx_valid_r <= tx_valid_s;
            data_in_r  <= data_in_s;
            cs_sel_r   <= cs_sel_s;
        end
    end

    assign bus.gnt          = gnt_r;
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.rd_data      = rd_data_r;
    assign bus.spi_tx_valid = tx_valid_r;
    assign bus.spi_data_in  = data_in_r;
    assign bus.spi_cs_sel   = cs_sel_r;
endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: directed requests, a behavioural spi_master
// that replies with Data_in[7:0] ^ 8'h96, and a negedge monitor checking issues and completions.
module tb_spi_arbiter;
    localparam int N_REQ   = 4;
    localparam int DW      = 14;
    localparam int RW      = 8;
    localparam int TIMEOUT = 63;
    localparam int XFER    = 18;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic          cs;
    } iss_t;

    typedef struct {
        logic          is_err;
        int            idx;
        logic [RW-1:0] rd;
    } cmp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .RW(RW)) bus ();

    spi_arbiter #(.N_REQ(N_REQ), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] cmd_tab [N_REQ] = '{14'h0101, 14'h1234, 14'h2A55, 14'h3FF0};
    logic [RW-1:0] rd_tab  [N_REQ] = '{8'h97, 8'hA2, 8'hC3, 8'h66};
    logic [N_REQ-1:0] cs_tab = 4'b0110;

    iss_t iss_q[$];
    cmp_t cmp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   iss_cnt = 0;
    int   evt_cnt = 0;
    int   iss_cyc = 0;
    bit   busy = 1'b0;
    bit   stall = 1'b0;
    logic [N_REQ-1:0] cur_gnt;
    logic [DW-1:0]    cur_data;
    logic             cur_cs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_xfer(input int idx, input bit is_err);
        iss_t e;
        cmp_t c;
        e.idx = idx; e.data = cmd_tab[idx]; e.cs = cs_tab[idx];
        c.is_err = is_err; c.idx = idx; c.rd = rd_tab[idx];
        iss_q.push_back(e);
        cmp_q.push_back(c);
    endtask

    // Bounded wait on the monitor's issue (which=0) or completion (which=1) counter.
    task automatic wait_for(input string name, input int which, input int target);
        int n = 0;
        while (((which == 0) ? iss_cnt : evt_cnt) < target && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, 64'(((which == 0) ? iss_cnt : evt_cnt) >= target), 64'd1);
    endtask

    // Monitor: pops the scoreboard on every tx_valid, done and err, and checks hold rules.
    always @(negedge clk) begin
        cmp_t c;
        iss_t e;
        cyc++;
        if (rst === 1'b0) begin
            busy = 1'b0;
        end else begin
            if (bus.done !== 4'b0000 || bus.err === 1'b1) begin
                if (cmp_q.size() == 0) begin
                    check("unexpected_completion", {bus.done, 3'b000, bus.err}, 64'd0);
                end else begin
                    c = cmp_q.pop_front();
                    check("completion_kind", 64'(bus.err), 64'(c.is_err));
                    if (c.is_err) begin
                        check("err_gnt_cleared", 64'(bus.gnt), 64'd0);
                        check("err_no_done", 64'(bus.done), 64'd0);
                        check("err_latency", 64'(cyc - iss_cyc), 64'(TIMEOUT + 2));
                    end else begin
                        check("done_onehot", 64'(bus.done), 64'd1 << c.idx);
                        check("done_gnt", 64'(bus.gnt), 64'd1 << c.idx);
                        check("rd_data", 64'(bus.rd_data), 64'(c.rd));
                    end
                end
                busy = 1'b0;
                evt_cnt++;
            end
            if (bus.spi_tx_valid === 1'b1) begin
                check("tx_while_busy", 64'(busy), 64'd0);
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", 64'(bus.gnt), 64'd0);
                end else begin
                    e = iss_q.pop_front();
                    check("issue_gnt", 64'(bus.gnt), 64'd1 << e.idx);
                    check("issue_data", 64'(bus.spi_data_in), 64'(e.data));
                    check("issue_cs", 64'(bus.spi_cs_sel), 64'(e.cs));
                end
                busy = 1'b1;
                cur_gnt = bus.gnt; cur_data = bus.spi_data_in; cur_cs = bus.spi_cs_sel;
                iss_cyc = cyc;
                iss_cnt++;
            end else if (busy) begin
                check("hold_gnt", 64'(bus.gnt), 64'(cur_gnt));
                check("hold_data", 64'(bus.spi_data_in), 64'(cur_data));
                check("hold_cs", 64'(bus.spi_cs_sel), 64'(cur_cs));
            end
        end
    end

    // spi_master model: rx_ready drops one cycle after the issue, rises XFER cycles later with the reply.
    initial begin
        bit ab;
        bus.spi_rx_ready = 1'b1;
        bus.spi_data_out = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst === 1'b1 && bus.spi_tx_valid === 1'b1 && !stall) begin
                ab = 1'b0;
                for (int k = 0; k < XFER + 1 && !ab; k++) begin
                    @(posedge clk); #1;
                    if (rst === 1'b0) ab = 1'b1;
                    else if (k == 1) bus.spi_rx_ready = 1'b0;
                end
                if (!ab) bus.spi_data_out = bus.spi_data_in[7:0] ^ 8'h96;
                bus.spi_rx_ready = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.req = 4'hF;
        bus.req_data = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
        bus.req_cs_sel = cs_tab;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_tx_valid", 64'(bus.spi_tx_valid), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        check("rst_done_err", {bus.done, bus.err}, 64'd0);

        // Contention: all four held, expect 0,1,2,3,0.
        exp_xfer(0, 1'b0); exp_xfer(1, 1'b0); exp_xfer(2, 1'b0); exp_xfer(3, 1'b0); exp_xfer(0, 1'b0);
        rst = 1'b1;
        wait_for("wait_contention_iss", 0, 5);
        bus.req = 4'h0;
        wait_for("wait_contention_done", 1, 5);

        // Single request on requester 2, CS1, reply C3.
        exp_xfer(2, 1'b0);
        bus.req = 4'b0100;
        wait_for("wait_single_iss", 0, 6);
        bus.req = 4'h0;
        wait_for("wait_single_done", 1, 6);

        // Fairness: serve 3, then 1001 goes to 0 then 3.
        exp_xfer(3, 1'b0);
        bus.req = 4'b1000;
        wait_for("wait_rr3_iss", 0, 7);
        bus.req = 4'h0;
        wait_for("wait_rr3_done", 1, 7);
        exp_xfer(0, 1'b0); exp_xfer(3, 1'b0);
        bus.req = 4'b1001;
        wait_for("wait_rr_iss", 0, 9);
        bus.req = 4'h0;
        wait_for("wait_rr_done", 1, 9);

        // Timeout on requester 1 with rx_ready stuck high, then requester 2 served.
        stall = 1'b1;
        exp_xfer(1, 1'b1); exp_xfer(2, 1'b0);
        bus.req = 4'b0110;
        wait_for("wait_timeout_err", 1, 10);
        stall = 1'b0;
        bus.req = 4'b0100;
        wait_for("wait_after_to_iss", 0, 11);
        bus.req = 4'h0;
        wait_for("wait_after_to_done", 1, 11);

        // Reset inside WAIT_HI drops the transfer; ptr restarts at 0.
        exp_xfer(0, 1'b0);
        bus.req = 4'b0001;
        wait_for("wait_mid_iss", 0, 12);
        bus.req = 4'h0;
        repeat (8) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("midrst_gnt", 64'(bus.gnt), 64'd0);
        check("midrst_done_err", {bus.done, bus.err}, 64'd0);
        rst = 1'b1;
        cmp_q.delete();
        exp_xfer(1, 1'b0); exp_xfer(3, 1'b0);
        bus.req = 4'b1010;
        wait_for("wait_post_rst_iss", 0, 14);
        bus.req = 4'h0;
        wait_for("wait_post_rst_done", 1, 13);

        repeat (30) @(negedge clk);
        check("iss_q_empty", 64'(iss_q.size()), 64'd0);
        check("cmp_q_empty", 64'(cmp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
